// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 keyboard line to 11-bit {toggle, pressed, extended, code} event word
module ps2_key_receiver #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 12000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        key_valid,
   output logic        parity_err,
   output logic        frame_err
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] DATA   = 2'd1;
   localparam logic [1:0] PARITY = 2'd2;
   localparam logic [1:0] STOP   = 2'd3;
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    r_clk_s, r_dat_s;
   logic          r_filt;
   logic [FW-1:0] r_fcnt;
   logic [1:0]    r_state;
   logic [2:0]    r_bits;
   logic [7:0]    r_shift;
   logic          r_par;
   logic [TW-1:0] r_to;
   logic          r_emit;
   logic [7:0]    r_byte;
   logic          r_perr, r_ferr;
   logic          r_ext, r_rel;
   logic [2:0]    r_skip;
   logic [10:0]   r_key;
   logic          r_valid;
   logic          w_fall, w_dat, w_tout, w_stat;

   assign w_dat  = r_dat_s[1];
   assign w_fall = r_filt & ~r_clk_s[1] & (r_fcnt == FW'(FILTER_LEN - 1));
   assign w_tout = (r_state != IDLE) & ~w_fall & (r_to == TW'(TIMEOUT_CYCLES - 1));
   assign w_stat = ~r_ext & ~r_rel & (r_byte inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'hFC, 8'h00, 8'hFF});

   assign ps2_key    = r_key;
   assign key_valid  = r_valid;
   assign parity_err = r_perr;
   assign frame_err  = r_ferr;

   // two-FF synchronisers and glitch filter on the PS/2 clock
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_clk_s <= 2'b11;
         r_dat_s <= 2'b11;
         r_filt  <= 1'b1;
         r_fcnt  <= '0;
      end else begin
         r_clk_s <= {r_clk_s[0], ps2_clk};
         r_dat_s <= {r_dat_s[0], ps2_data};
         if (r_clk_s[1] == r_filt)
            r_fcnt <= '0;
         else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
            r_filt <= ~r_filt;
            r_fcnt <= '0;
         end else
            r_fcnt <= r_fcnt + 1'b1;
      end
   end

   // mid-frame watchdog, cleared by every falling edge
   always_ff @(posedge clk_sys) begin
      if (!reset_n || r_state == IDLE || w_fall)
         r_to <= '0;
      else
         r_to <= r_to + 1'b1;
   end

   // frame FSM: one step per filtered falling edge
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_bits  <= '0;
         r_shift <= '0;
         r_par   <= 1'b0;
         r_emit  <= 1'b0;
         r_byte  <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_emit <= 1'b0;
         r_perr <= 1'b0;
         r_ferr <= 1'b0;
         if (w_fall) begin
            case (r_state)
               IDLE: begin
                  r_state <= w_dat ? IDLE : DATA;
                  r_ferr  <= w_dat;
                  r_bits  <= '0;
               end
               DATA: begin
                  r_shift <= {w_dat, r_shift[7:1]};
                  r_bits  <= r_bits + 1'b1;
                  r_state <= (r_bits == 3'd7) ? PARITY : DATA;
               end
               PARITY: begin
                  r_par   <= w_dat;
                  r_state <= STOP;
               end
               default: begin
                  r_state <= IDLE;
                  r_emit  <= w_dat & (^{r_shift, r_par});
                  r_perr  <= w_dat & ~(^{r_shift, r_par});
                  r_ferr  <= ~w_dat;
                  r_byte  <= r_shift;
               end
            endcase
         end else if (w_tout) begin
            r_state <= IDLE;
            r_ferr  <= 1'b1;
         end
      end
   end

   // byte decoder: prefixes, Pause suppression, status-byte filtering, event word
   always_ff @(posedge clk_sys) begin
      if (!reset_n) begin
         r_ext   <= 1'b0;
         r_rel   <= 1'b0;
         r_skip  <= '0;
         r_key   <= '0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (r_emit) begin
            if (r_skip != 3'd0)
               r_skip <= r_skip - 1'b1;
            else if (r_byte == 8'hE1) begin
               r_skip <= 3'd7;
               r_ext  <= 1'b0;
               r_rel  <= 1'b0;
            end else if (r_byte == 8'hE0)
               r_ext <= 1'b1;
            else if (r_byte == 8'hF0)
               r_rel <= 1'b1;
            else if (!w_stat) begin
               r_key   <= {~r_key[10], ~r_rel, r_ext, r_byte};
               r_valid <= 1'b1;
               r_ext   <= 1'b0;
               r_rel   <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb_ps2_key_receiver: directed frame vectors and corner sequences for ps2_key_receiver
module tb_ps2_key_receiver;
   localparam int TO = 12000;

   logic        clk_sys = 1'b0;
   logic        reset_n = 1'b0;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic [10:0] ps2_key;
   logic        key_valid, parity_err, frame_err;

   int n_cmp = 0, n_bad = 0;
   int n_kv = 0, n_pe = 0, n_fe = 0;

   typedef struct {
      logic [7:0]  b;
      logic        badpar;
      logic        stop;
      logic [10:0] key;
      int          kv, pe, fe;
   } vec_t;

   vec_t vec [15];

   ps2_key_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .ps2_key(ps2_key), .key_valid(key_valid), .parity_err(parity_err), .frame_err(frame_err)
   );

   always #5 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (key_valid) n_kv++;
      if (parity_err) n_pe++;
      if (frame_err) n_fe++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_sys) ps2_data = f[i];
         repeat (10) @(negedge clk_sys);
         ps2_clk = 1'b0;
         repeat (20) @(negedge clk_sys);
         ps2_clk = 1'b1;
         repeat (10) @(negedge clk_sys);
      end
      ps2_data = 1'b1;
      repeat (20) @(negedge clk_sys);
   endtask

   task automatic send(input logic [7:0] b, input logic badpar, input logic stop);
      send_bits({stop, (~^b) ^ badpar, b, 1'b0}, 11);
   endtask

   initial begin
      int kv0, pe0, fe0;
      logic [7:0] pause [8];
      vec[0]  = '{8'h29, 1'b0, 1'b1, 11'h629, 1, 0, 0};
      vec[1]  = '{8'hF0, 1'b0, 1'b1, 11'h629, 0, 0, 0};
      vec[2]  = '{8'h29, 1'b0, 1'b1, 11'h029, 1, 0, 0};
      vec[3]  = '{8'hE0, 1'b0, 1'b1, 11'h029, 0, 0, 0};
      vec[4]  = '{8'h75, 1'b0, 1'b1, 11'h775, 1, 0, 0};
      vec[5]  = '{8'hE0, 1'b0, 1'b1, 11'h775, 0, 0, 0};
      vec[6]  = '{8'hF0, 1'b0, 1'b1, 11'h775, 0, 0, 0};
      vec[7]  = '{8'h75, 1'b0, 1'b1, 11'h175, 1, 0, 0};
      vec[8]  = '{8'h1C, 1'b1, 1'b1, 11'h175, 0, 1, 0};
      vec[9]  = '{8'h1C, 1'b0, 1'b1, 11'h61C, 1, 0, 0};
      vec[10] = '{8'hAA, 1'b0, 1'b1, 11'h61C, 0, 0, 0};
      vec[11] = '{8'hE0, 1'b0, 1'b1, 11'h61C, 0, 0, 0};
      vec[12] = '{8'hAA, 1'b0, 1'b1, 11'h3AA, 1, 0, 0};
      vec[13] = '{8'h3C, 1'b0, 1'b0, 11'h3AA, 0, 0, 1};
      vec[14] = '{8'h3C, 1'b0, 1'b1, 11'h63C, 1, 0, 0};
      pause = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

      repeat (4) @(negedge clk_sys);
      chk("reset_key", int'(ps2_key), 0);
      chk("reset_pulses", int'({key_valid, parity_err, frame_err}), 0);
      reset_n = 1'b1;
      repeat (20) @(negedge clk_sys);
      chk("idle_no_err", n_fe + n_pe + n_kv, 0);

      for (int i = 0; i < 15; i++) begin
         kv0 = n_kv; pe0 = n_pe; fe0 = n_fe;
         send(vec[i].b, vec[i].badpar, vec[i].stop);
         chk($sformatf("v%0d_key", i), int'(ps2_key), int'(vec[i].key));
         chk($sformatf("v%0d_kv", i), n_kv - kv0, vec[i].kv);
         chk($sformatf("v%0d_pe", i), n_pe - pe0, vec[i].pe);
         chk($sformatf("v%0d_fe", i), n_fe - fe0, vec[i].fe);
      end

      kv0 = n_kv; fe0 = n_fe;
      send_bits({2'b11, 8'h16, 1'b0}, 5);
      repeat (TO + 2) @(negedge clk_sys);
      chk("timeout_fe", n_fe - fe0, 1);
      chk("timeout_kv", n_kv - kv0, 0);
      send(8'h16, 1'b0, 1'b1);
      chk("after_to_key", int'(ps2_key), 'h216);
      chk("after_to_kv", n_kv - kv0, 1);

      fe0 = n_fe; kv0 = n_kv;
      @(negedge clk_sys) ps2_clk = 1'b0;
      repeat (5) @(negedge clk_sys);
      ps2_clk = 1'b1;
      repeat (40) @(negedge clk_sys);
      chk("glitch_fe", n_fe - fe0, 0);
      send(8'h2E, 1'b1, 1'b1);
      chk("glitch_no_bit_pe", n_pe - 1, 1);
      chk("glitch_key", int'(ps2_key), 'h216);

      kv0 = n_kv;
      for (int i = 0; i < 8; i++) send(pause[i], 1'b0, 1'b1);
      chk("pause_kv", n_kv - kv0, 0);
      send(8'h2E, 1'b0, 1'b1);
      chk("pause_after_key", int'(ps2_key), 'h62E);
      chk("pause_after_kv", n_kv - kv0, 1);

      kv0 = n_kv; pe0 = n_pe; fe0 = n_fe;
      send_bits({2'b11, 8'h29, 1'b0}, 4);
      @(negedge clk_sys) reset_n = 1'b0;
      repeat (3) @(negedge clk_sys);
      chk("midrst_key", int'(ps2_key), 0);
      reset_n = 1'b1;
      repeat (TO / 4) @(negedge clk_sys);
      chk("midrst_pulses", (n_kv - kv0) + (n_pe - pe0) + (n_fe - fe0), 0);
      send(8'h29, 1'b0, 1'b1);
      chk("midrst_next_key", int'(ps2_key), 'h629);
      chk("midrst_next_kv", n_kv - kv0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
